// File: rtl/oact_drain_if.sv
// Handshake bundles for the output-activation drain:
// vector push from the PE matrix and beat stream to the output buffer.
interface oact_push_if #(
    parameter int DATA_BITWIDTH  = 8,
    parameter int NUM_OF_WEIGHT  = 32,
    parameter int OADDR_BITWIDTH = 10
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [NUM_OF_WEIGHT*DATA_BITWIDTH-1:0]  oacts;
    logic [OADDR_BITWIDTH-1:0]               base_addr;

    modport master (
        output in_valid,
        output oacts,
        output base_addr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  oacts,
        input  base_addr,
        output in_ready
    );
endinterface

interface oact_beat_if #(
    parameter int DATA_BITWIDTH  = 8,
    parameter int LANES_PER_BEAT = 8,
    parameter int OADDR_BITWIDTH = 10
);
    logic                                    out_valid;
    logic                                    out_ready;
    logic [LANES_PER_BEAT*DATA_BITWIDTH-1:0] out_data;
    logic [OADDR_BITWIDTH-1:0]               out_addr;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );
endinterface

// File: rtl/oact_drain.sv
// Output-activation drain: vector FIFO plus beat serializer.
// Define OACT_RELU_EN to clamp negative lanes to zero at push.
module oact_drain #(
    parameter int DATA_BITWIDTH  = 8,
    parameter int NUM_OF_WEIGHT  = 32,
    parameter int LANES_PER_BEAT = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int OADDR_BITWIDTH = 10
) (
    input  logic       clk,
    input  logic       rst,
    oact_push_if.slave push,
    oact_beat_if.master beat,
    output logic       busy,
    output logic       overflow
);

    localparam int VW    = NUM_OF_WEIGHT * DATA_BITWIDTH;
    localparam int BW    = LANES_PER_BEAT * DATA_BITWIDTH;
    localparam int BEATS = NUM_OF_WEIGHT / LANES_PER_BEAT;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int AW    = OADDR_BITWIDTH;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    logic [VW-1:0]  mem_data_q [FIFO_DEPTH];
    logic [AW-1:0]  mem_addr_q [FIFO_DEPTH];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [VW-1:0]  shreg_q, shreg_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic           ovf_q, ovf_d;
    state_e         state_q, state_d;

    logic           fifo_empty;
    logic           fifo_full;
    logic           push_en;
    logic           pop_en;
    logic           fire;
    logic           last_beat;
    logic [VW-1:0]  wdata;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

    // Occupancy is the registered count, so a same-cycle pop never frees a slot.
    assign push.in_ready = !rst && !fifo_full;
    assign push_en       = push.in_valid && push.in_ready;

`ifdef OACT_RELU_EN
    always_comb begin
        wdata = push.oacts;
        for (int k = 0; k < NUM_OF_WEIGHT; k++) begin
            if (push.oacts[k*DATA_BITWIDTH + DATA_BITWIDTH - 1]) begin
                wdata[k*DATA_BITWIDTH +: DATA_BITWIDTH] = '0;
            end
        end
    end
`else
    assign wdata = push.oacts;
`endif

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_data_q[wr_ptr_q] <= wdata;
            mem_addr_q[wr_ptr_q] <= push.base_addr;
        end
    end

    assign fire      = (state_q == SEND) && beat.out_ready;
    assign last_beat = (bcnt_q == BCW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        pop_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_en  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (fire && last_beat) begin
                    if (!fifo_empty) begin
                        pop_en = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        shreg_d  = shreg_q;
        addr_d   = addr_q;
        bcnt_d   = bcnt_q;
        wr_ptr_d = wr_ptr_q + PW'(push_en);
        rd_ptr_d = rd_ptr_q + PW'(pop_en);
        count_d  = count_q + CW'(push_en) - CW'(pop_en);
        ovf_d    = ovf_q | (push.in_valid && !push.in_ready);
        if (pop_en) begin
            shreg_d = mem_data_q[rd_ptr_q];
            addr_d  = mem_addr_q[rd_ptr_q];
            bcnt_d  = '0;
        end else if (fire) begin
            shreg_d = shreg_q >> BW;
            addr_d  = addr_q + AW'(1);
            bcnt_d  = bcnt_q + BCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shreg_q  <= '0;
            addr_q   <= '0;
            bcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shreg_q  <= shreg_d;
            addr_q   <= addr_d;
            bcnt_q   <= bcnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign beat.out_valid = (state_q == SEND);
    assign beat.out_data  = shreg_q[BW-1:0];
    assign beat.out_addr  = addr_q;
    assign busy           = !fifo_empty || (state_q == SEND);
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_oact_drain.sv
// Directed + randomized bench for oact_drain against a
// queue-based model of vectors and pending beats.
module tb_oact_drain;

    localparam int DW    = 8;
    localparam int NW    = 32;
    localparam int LPB   = 8;
    localparam int FD    = 4;
    localparam int AW    = 10;
    localparam int BEATS = NW / LPB;
    localparam int BW    = LPB * DW;
    localparam int VW    = NW * DW;

    typedef struct {
        logic [BW-1:0] data;
        logic [AW-1:0] addr;
    } beat_t;

    typedef struct {
        logic [VW-1:0] data;
        logic [AW-1:0] base;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic overflow;

    always #5 clk = ~clk;

    oact_push_if #(
        .DATA_BITWIDTH (DW),
        .NUM_OF_WEIGHT (NW),
        .OADDR_BITWIDTH(AW)
    ) pif ();

    oact_beat_if #(
        .DATA_BITWIDTH (DW),
        .LANES_PER_BEAT(LPB),
        .OADDR_BITWIDTH(AW)
    ) bif ();

    oact_drain #(
        .DATA_BITWIDTH (DW),
        .NUM_OF_WEIGHT (NW),
        .LANES_PER_BEAT(LPB),
        .FIFO_DEPTH    (FD),
        .OADDR_BITWIDTH(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (pif),
        .beat    (bif),
        .busy    (busy),
        .overflow(overflow)
    );

    vec_t  fifo_m[$];
    beat_t cur_m[$];
    bit    ovf_m;
    int    checks;
    int    errors;
    int    dut_xfers;
    int    mdl_xfers;

    function automatic logic [VW-1:0] relu(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
`ifdef OACT_RELU_EN
        for (int k = 0; k < NW; k++) begin
            if ($signed(v[k*DW +: DW]) < 0) r[k*DW +: DW] = '0;
        end
`endif
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model advances one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit   fire;
        bit   load;
        bit   full;
        vec_t v;
        if (rst) begin
            fifo_m.delete();
            cur_m.delete();
            ovf_m = 1'b0;
            return;
        end
        fire = (cur_m.size() > 0) && bif.out_ready;
        load = (cur_m.size() == 0) || (fire && cur_m.size() == 1);
        full = (fifo_m.size() == FD);
        if (fire) begin
            void'(cur_m.pop_front());
            mdl_xfers++;
        end
        if (load && fifo_m.size() > 0) begin
            v = fifo_m.pop_front();
            for (int b = 0; b < BEATS; b++)
                cur_m.push_back('{v.data[b*BW +: BW], v.base + AW'(b)});
        end
        if (pif.in_valid) begin
            if (!full) fifo_m.push_back('{relu(pif.oacts), pif.base_addr});
            else ovf_m = 1'b1;
        end
    endtask

    task automatic compare();
        chk("out_valid", bif.out_valid, cur_m.size() > 0);
        chk("busy", busy, fifo_m.size() > 0 || cur_m.size() > 0);
        chk("in_ready", pif.in_ready, !rst && fifo_m.size() < FD);
        chk("overflow", overflow, ovf_m);
        if (cur_m.size() > 0) begin
            chk("out_data", bif.out_data, cur_m[0].data);
            chk("out_addr", bif.out_addr, cur_m[0].addr);
        end
    endtask

    task automatic cycle();
        if (!rst && bif.out_valid && bif.out_ready) dut_xfers++;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic push_vec(input logic [VW-1:0] v, input logic [AW-1:0] b);
        pif.in_valid  = 1'b1;
        pif.oacts     = v;
        pif.base_addr = b;
        cycle();
        pif.in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        pif.in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        logic [VW-1:0] v;
        logic [AW-1:0] wrap_seq [4];
        bit            bp_seq [9];
        int            base;

        checks        = 0;
        errors        = 0;
        dut_xfers     = 0;
        mdl_xfers     = 0;
        ovf_m         = 1'b0;
        rst           = 1'b1;
        pif.in_valid  = 1'b0;
        pif.oacts     = '0;
        pif.base_addr = '0;
        bif.out_ready = 1'b0;

        // Reset state
        idle(2);
        chk("rst_out_data", bif.out_data, 0);
        chk("rst_out_addr", bif.out_addr, 0);
        chk("rst_in_ready", pif.in_ready, 0);
        rst = 1'b0;
        idle(1);
        chk("post_rst_in_ready", pif.in_ready, 1);

        // Single vector, lanes k+1, latency and beat layout
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = DW'(k + 1);
        bif.out_ready = 1'b1;
        base = dut_xfers;
        push_vec(v, 10'h100);
        chk("lat_t1_valid", bif.out_valid, 0);
        cycle();
        chk("lat_t2_valid", bif.out_valid, 1);
        chk("beat0_data", bif.out_data, 64'h0807060504030201);
        chk("beat0_addr", bif.out_addr, 10'h100);
        idle(3);
        chk("beat3_data", bif.out_data, 64'h201f1e1d1c1b1a19);
        chk("beat3_addr", bif.out_addr, 10'h103);
        idle(1);
        chk("single_busy_low", busy, 0);
        chk("single_xfers", dut_xfers - base, BEATS);

        // Backpressure
        bp_seq = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
        base = dut_xfers;
        push_vec(rand_vec(), AW'($urandom()));
        for (int i = 0; i < 9; i++) begin
            bif.out_ready = bp_seq[i];
            cycle();
        end
        bif.out_ready = 1'b1;
        idle(4);
        chk("bp_xfers", dut_xfers - base, BEATS);

        // Overflow: one vector moves to the serializer, four fill the FIFO
        bif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_vec(rand_vec(), AW'($urandom()));
        chk("ovf_in_ready_low", pif.in_ready, 0);
        chk("ovf_not_yet", overflow, 0);
        push_vec(rand_vec(), AW'($urandom()));
        chk("ovf_set", overflow, 1);
        base = dut_xfers;
        bif.out_ready = 1'b1;
        idle(30);
        chk("ovf_drained", dut_xfers - base, 5 * BEATS);
        chk("ovf_sticky", overflow, 1);

        // Address wrap
        wrap_seq = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        push_vec(rand_vec(), 10'h3FE);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("wrap_addr", bif.out_addr, wrap_seq[i]);
        end
        idle(2);

        // Reset mid-stream
        bif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_vec(rand_vec(), AW'($urandom()));
        bif.out_ready = 1'b1;
        idle(2);
        base = dut_xfers;
        rst = 1'b1;
        idle(1);
        chk("mid_rst_valid", bif.out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        rst = 1'b0;
        idle(8);
        chk("mid_rst_no_beats", dut_xfers - base, 0);

        // Lane clamp behaviour
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = 8'h10;
        v[7:0]  = 8'h80;
        v[15:8] = 8'h7F;
        push_vec(v, 10'h020);
        cycle();
`ifdef OACT_RELU_EN
        chk("relu_beat0", bif.out_data, 64'h1010101010107F00);
`else
        chk("relu_beat0", bif.out_data, 64'h1010101010107F80);
`endif
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            pif.in_valid  = ($urandom_range(0, 3) == 0);
            pif.oacts     = rand_vec();
            pif.base_addr = AW'($urandom());
            bif.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        pif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 200 && (fifo_m.size() > 0 || cur_m.size() > 0); i++)
            cycle();
        chk("drain_bound", fifo_m.size() + cur_m.size(), 0);
        idle(1);
        chk("drain_busy", busy, 0);
        chk("xfer_total", dut_xfers, mdl_xfers);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
